// File: rtl/i2c_target_pkg.sv
// Shared types for the I2C target: FSM state encoding and SDA drive levels.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_t;

  localparam logic OE_ACK  = 1'b1;
  localparam logic OE_NACK = 1'b0;

endpackage

// File: rtl/i2c_target_regif_line_filter.sv
// Pad-input conditioning: 2-FF synchronizer, stability filter and edge pulses.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_LEN - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Reset to the idle-bus level so a released line does not look like an edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= CNT_LOAD;
    end else begin
      r_sync1 <= i_line;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= CNT_LOAD;
      end else if (r_cnt == '0) begin
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_fall  <= ~r_sync2;
        r_cnt   <= CNT_LOAD;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target bridging bus transactions to an 8-bit register interface.
//   state       | meaning
//   IDLE        | bus free or not addressed since reset
//   ADDR        | shifting in address + R/W
//   ADDR_ACK    | ACKing the address (read: first fetch on its rising edge)
//   PTR/PTR_ACK | receiving / ACKing the register pointer
//   WDATA(_ACK) | receiving / ACKing write data
//   RDATA(_ACK) | driving read data / sampling controller ACK
//   IGNORE      | not ours or read ended; wait for STOP or START
module i2c_target_regif
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic [7:0] o_reg_addr,
  output logic       o_reg_wr_en,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_rd_en,
  input  logic [7:0] i_reg_rdata,
  output logic       o_busy
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .i_clk(i_clk), .i_rst(i_rst), .i_line(i_scl),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .i_clk(i_clk), .i_rst(i_rst), .i_line(i_sda),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  state_t     r_state;
  logic [3:0] r_bitcnt;
  logic [6:0] r_shift;
  logic [7:0] r_tx;
  logic       r_rw;
  logic       r_fetch;
  logic [7:0] r_ptr;
  logic       r_sda_oe;
  logic       r_wr_en;
  logic [7:0] r_wdata;
  logic       r_rd_en;
  logic       r_busy;

  logic       w_start, w_stop, w_last_bit;
  logic [7:0] w_byte;

  // An SCL edge in the same cycle as the SDA edge means a data bit, not START/STOP.
  assign w_start    = w_sda_fall & w_scl & ~w_scl_rise;
  assign w_stop     = w_sda_rise & w_scl & ~w_scl_rise;
  assign w_byte     = {r_shift, w_sda};
  assign w_last_bit = (r_bitcnt == 4'd7);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= 4'd0;
      r_shift  <= 7'd0;
      r_tx     <= 8'd0;
      r_rw     <= 1'b0;
      r_fetch  <= 1'b0;
      r_ptr    <= 8'd0;
      r_sda_oe <= OE_NACK;
      r_wr_en  <= 1'b0;
      r_wdata  <= 8'd0;
      r_rd_en  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_fetch <= r_rd_en;
      if (r_fetch) r_tx <= i_reg_rdata;

      if (w_start) begin
        r_state  <= S_ADDR;
        r_bitcnt <= 4'd0;
        r_sda_oe <= OE_NACK;
        r_busy   <= 1'b0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_bitcnt <= 4'd0;
        r_sda_oe <= OE_NACK;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte[6:0];
              r_bitcnt <= r_bitcnt + 4'd1;
              if (w_last_bit) begin
                if (r_state == S_ADDR) begin
                  if (w_byte[7:1] == SLAVE_ADDR) begin
                    r_state <= S_ADDR_ACK;
                    r_rw    <= w_byte[0];
                    r_busy  <= 1'b1;
                  end else begin
                    r_state <= S_IGNORE;
                  end
                end else if (r_state == S_PTR) begin
                  r_ptr   <= w_byte;
                  r_state <= S_PTR_ACK;
                end else begin
                  r_wr_en <= 1'b1;
                  r_wdata <= w_byte;
                  r_state <= S_WDATA_ACK;
                end
              end
            end
          end
          // bitcnt==8 marks the fall that opens the ACK clock; 0 marks the fall that closes it
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (r_bitcnt == 4'd8) begin
                r_sda_oe <= OE_ACK;
                r_bitcnt <= 4'd0;
              end else if (r_rw) begin
                r_state  <= S_RDATA;
                r_sda_oe <= ~r_tx[7];
                r_tx     <= {r_tx[6:0], 1'b0};
              end else begin
                r_state  <= S_PTR;
                r_sda_oe <= OE_NACK;
              end
            end else if (w_scl_rise && r_rw) begin
              r_rd_en <= 1'b1;
            end
          end
          S_PTR_ACK, S_WDATA_ACK: begin
            if (w_scl_fall) begin
              if (r_bitcnt == 4'd8) begin
                r_sda_oe <= OE_ACK;
                r_bitcnt <= 4'd0;
              end else begin
                r_sda_oe <= OE_NACK;
                r_state  <= S_WDATA;
                if (r_state == S_WDATA_ACK) r_ptr <= r_ptr + 8'd1;
              end
            end
          end
          S_RDATA: begin
            if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bitcnt == 4'd8) begin
                r_sda_oe <= OE_NACK;
                r_bitcnt <= 4'd0;
                r_state  <= S_RDATA_ACK;
              end else begin
                r_sda_oe <= ~r_tx[7];
                r_tx     <= {r_tx[6:0], 1'b0};
              end
            end
          end
          S_RDATA_ACK: begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                r_ptr   <= r_ptr + 8'd1;
                r_rd_en <= 1'b1;
              end else begin
                r_state <= S_IGNORE;
              end
            end else if (w_scl_fall) begin
              r_state  <= S_RDATA;
              r_bitcnt <= 4'd0;
              r_sda_oe <= ~r_tx[7];
              r_tx     <= {r_tx[6:0], 1'b0};
            end
          end
          S_IDLE, S_IGNORE: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_sda_oe    = r_sda_oe;
  assign o_reg_addr  = r_ptr;
  assign o_reg_wr_en = r_wr_en;
  assign o_reg_wdata = r_wdata;
  assign o_reg_rd_en = r_rd_en;
  assign o_busy      = r_busy;

endmodule
